decoder_8bit_pulse: RTL and testbench

Sequential 3-to-8 decoder. It accepts a 3-bit code and a valid flag, and drives the matching one-hot line of an 8-bit output for a programmable number of cycles. A valid/ready handshake throttles the source, and a mandatory all-zero gap cycle separates consecutive pulses, so repeated identical codes stay distinguishable downstream. Sits on the consumer side of the 8-bit priority encoder: it turns {out, valid} code streams back into per-line strobes.

---
 rtl/decoder_8bit_pulse_pkg.sv | 14 +
 rtl/decoder_8bit_pulse_if.sv | 23 ++
 rtl/decoder_8bit_pulse_onehot.sv | 13 +
 rtl/decoder_8bit_pulse.sv | 123 ++++++++++++
 tb/tb_decoder_8bit_pulse.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/decoder_8bit_pulse_pkg.sv
// Shared types and constants for the 3-to-8 pulse decoder.
package decoder_pkg;

    localparam int unsigned CODE_W   = 3;
    localparam int unsigned ONEHOT_W = 8;

    // 2'b11 is unused and falls back to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HOLD = 2'b01,
        GAP  = 2'b10
    } state_e;

endpackage

// File: rtl/decoder_8bit_pulse_if.sv
// Code/strobe bundle between a code source (master) and the pulse decoder (slave).
// History ports exist only when DEC_HISTORY_EN is defined.
interface decoder_8bit_pulse_if;
    import decoder_pkg::*;

    logic [CODE_W-1:0]   in;
    logic                valid;
    logic                ready;
    logic [ONEHOT_W-1:0] out;
    logic                active;
    logic                done;
`ifdef DEC_HISTORY_EN
    logic                hist_clr;
    logic [ONEHOT_W-1:0] hist;

    modport master (output in, valid, hist_clr, input ready, out, active, done, hist);
    modport slave  (input in, valid, hist_clr, output ready, out, active, done, hist);
`else
    modport master (output in, valid, input ready, out, active, done);
    modport slave  (input in, valid, output ready, out, active, done);
`endif

endinterface

// File: rtl/decoder_8bit_pulse_onehot.sv
// Purely combinational 3-bit code to 8-bit one-hot conversion.
module onehot_3to8
    import decoder_pkg::*;
(
    input  logic [CODE_W-1:0]   code,
    output logic [ONEHOT_W-1:0] onehot_c
);

    always_comb begin
        onehot_c = ONEHOT_W'(1) << code;
    end

endmodule

// File: rtl/decoder_8bit_pulse.sv
// Sequential 3-to-8 decoder: each accepted code becomes a HOLD_CYCLES one-hot pulse plus a zero gap cycle.
// Optional sticky history of decoded lines is enabled with DEC_HISTORY_EN.
module decoder_8bit_pulse
    import decoder_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    decoder_8bit_pulse_if.slave  bus
);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ONEHOT_W-1:0] out_q, out_d;
    logic                active_q, active_d;
    logic                done_q, done_d;
    logic                ready_q, ready_d;
    logic [ONEHOT_W-1:0] onehot_c;
    logic                accept_c;

    onehot_3to8 u_onehot (
        .code     (bus.in),
        .onehot_c (onehot_c)
    );

    assign accept_c = bus.valid & ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            out_q    <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            active_q <= active_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
        end
    end

    // Next-state and registered-output values; done is a one-cycle flag into GAP.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        active_d = active_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                out_d    = '0;
                active_d = 1'b0;
                if (accept_c) begin
                    cnt_d    = CNT_W'(HOLD_CYCLES - 1);
                    out_d    = onehot_c;
                    active_d = 1'b1;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    out_d    = '0;
                    active_d = 1'b0;
                    done_d   = 1'b1;
                    state_d  = GAP;
                end
            end
            GAP: begin
                out_d    = '0;
                active_d = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                cnt_d    = '0;
                out_d    = '0;
                active_d = 1'b0;
                state_d  = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
    end

    assign bus.out    = out_q;
    assign bus.active = active_q;
    assign bus.done   = done_q;
    assign bus.ready  = ready_q;

`ifdef DEC_HISTORY_EN
    logic [ONEHOT_W-1:0] hist_q, hist_d;

    // Clear drops old bits first so a coinciding accept leaves only the new line.
    always_comb begin
        hist_d = hist_q;
        if (bus.hist_clr) begin
            hist_d = '0;
        end
        if (accept_c) begin
            hist_d = hist_d | onehot_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign bus.hist = hist_q;
`endif

endmodule

// File: tb/tb_decoder_8bit_pulse.sv
// Directed bench for decoder_8bit_pulse: one instance with HOLD_CYCLES=4, one with HOLD_CYCLES=1.
module tb_decoder_8bit_pulse;
    import decoder_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic [7:0] exp_oh;

    always #5 clk = ~clk;

    decoder_8bit_pulse_if bus_a ();
    decoder_8bit_pulse_if bus_b ();

    decoder_8bit_pulse #(.HOLD_CYCLES(4), .CNT_W(8)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    decoder_8bit_pulse #(.HOLD_CYCLES(1), .CNT_W(8)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    // Compares {out, active, done, ready} (or a zero-extended hist) against the expected pattern.
    task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        bus_a.in = '0; bus_a.valid = 1'b0;
        bus_b.in = '0; bus_b.valid = 1'b0;
`ifdef DEC_HISTORY_EN
        bus_a.hist_clr = 1'b0;
        bus_b.hist_clr = 1'b0;
`endif
        // Reset
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_a", {bus_a.out, bus_a.active, bus_a.done, bus_a.ready}, {8'h00, 3'b001});
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rel_a", {bus_a.out, bus_a.active, bus_a.done, bus_a.ready}, {8'h00, 3'b001});
        chk("rst_rel_b", {bus_b.out, bus_b.active, bus_b.done, bus_b.ready}, {8'h00, 3'b001});

        // Single code 5
        bus_a.in = 3'd5; bus_a.valid = 1'b1;
        @(negedge clk);
        bus_a.valid = 1'b0; bus_a.in = 3'd1;
        for (int i = 0; i < 4; i++) begin
            chk("single_hold", {bus_a.out, bus_a.active, bus_a.done, bus_a.ready}, {8'h20, 3'b100});
            @(negedge clk);
        end
        chk("single_gap", {bus_a.out, bus_a.active, bus_a.done, bus_a.ready}, {8'h00, 3'b010});
        @(negedge clk);
        chk("single_idle", {bus_a.out, bus_a.active, bus_a.done, bus_a.ready}, {8'h00, 3'b001});

        // Back-to-back code 7 with valid held high
        bus_a.in = 3'd7; bus_a.valid = 1'b1;
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 4; i++) begin
                chk("b2b_hold", {bus_a.out, bus_a.active, bus_a.done, bus_a.ready}, {8'h80, 3'b100});
                @(negedge clk);
            end
            chk("b2b_gap", {bus_a.out, bus_a.active, bus_a.done, bus_a.ready}, {8'h00, 3'b010});
            @(negedge clk);
            chk("b2b_idle", {bus_a.out, bus_a.active, bus_a.done, bus_a.ready}, {8'h00, 3'b001});
            if (p == 1) bus_a.valid = 1'b0;
            @(negedge clk);
        end
        chk("b2b_end", {bus_a.out, bus_a.active, bus_a.done, bus_a.ready}, {8'h00, 3'b001});

        // Stall with code change 2 -> 6
        bus_a.in = 3'd2; bus_a.valid = 1'b1;
        @(negedge clk);
        chk("stall_first", {bus_a.out, bus_a.active, bus_a.done, bus_a.ready}, {8'h04, 3'b100});
        bus_a.in = 3'd6;
        repeat (4) @(negedge clk);
        chk("stall_gap", {bus_a.out, bus_a.active, bus_a.done, bus_a.ready}, {8'h00, 3'b010});
        @(negedge clk);
        chk("stall_idle", {bus_a.out, bus_a.active, bus_a.done, bus_a.ready}, {8'h00, 3'b001});
        @(negedge clk);
        chk("stall_second", {bus_a.out, bus_a.active, bus_a.done, bus_a.ready}, {8'h40, 3'b100});
        bus_a.valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("stall_gap2", {bus_a.out, bus_a.active, bus_a.done, bus_a.ready}, {8'h00, 3'b010});
        @(negedge clk);

        // HOLD_CYCLES=1 sweep of all codes
        for (int c = 0; c < 8; c++) begin
            exp_oh = 8'h01 << c;
            bus_b.in = 3'(c); bus_b.valid = 1'b1;
            @(negedge clk);
            chk("sweep_strobe", {bus_b.out, bus_b.active, bus_b.done, bus_b.ready}, {exp_oh, 3'b100});
            bus_b.valid = 1'b0;
            @(negedge clk);
            chk("sweep_gap", {bus_b.out, bus_b.active, bus_b.done, bus_b.ready}, {8'h00, 3'b010});
            @(negedge clk);
            chk("sweep_idle", {bus_b.out, bus_b.active, bus_b.done, bus_b.ready}, {8'h00, 3'b001});
        end

        // Asynchronous reset while out=8'h10
        bus_a.in = 3'd4; bus_a.valid = 1'b1;
        @(negedge clk);
        bus_a.valid = 1'b0;
        chk("arst_pre", {bus_a.out, bus_a.active, bus_a.done, bus_a.ready}, {8'h10, 3'b100});
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("arst_now", {bus_a.out, bus_a.active, bus_a.done, 1'b0}, {8'h00, 3'b000});
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("arst_after", {bus_a.out, bus_a.active, bus_a.done, bus_a.ready}, {8'h00, 3'b001});
        end

`ifdef DEC_HISTORY_EN
        chk("hist_rst", 11'(bus_a.hist), 11'h000);
        bus_a.in = 3'd1; bus_a.valid = 1'b1;
        @(negedge clk);
        bus_a.valid = 1'b0;
        chk("hist_code1", 11'(bus_a.hist), 11'h002);
        repeat (5) @(negedge clk);
        bus_a.in = 3'd4; bus_a.valid = 1'b1;
        @(negedge clk);
        bus_a.valid = 1'b0;
        chk("hist_code4", 11'(bus_a.hist), 11'h012);
        repeat (5) @(negedge clk);
        bus_a.hist_clr = 1'b1; bus_a.in = 3'd0; bus_a.valid = 1'b1;
        @(negedge clk);
        bus_a.hist_clr = 1'b0; bus_a.valid = 1'b0;
        chk("hist_clr_accept", 11'(bus_a.hist), 11'h001);
        repeat (5) @(negedge clk);
        bus_a.hist_clr = 1'b1;
        @(negedge clk);
        bus_a.hist_clr = 1'b0;
        chk("hist_clr_only", 11'(bus_a.hist), 11'h000);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
